// File: rtl/jtpang_objdma_if.sv
// Bus/handshake bundle between the object-RAM DMA engine and the rest of the
// Pang main board: CPU-side trigger, Z80 bus request/acknowledge, video RAM
// read port and object RAM write port.
interface jtpang_objdma_if #(
    parameter int AW = 9
);
    logic          dma_go;
    logic          busak_n;
    logic          busrq_n;
    logic          dma_sel;
    logic [11:0]   src_addr;
    logic [7:0]    src_din;
    logic [AW-1:0] obj_addr;
    logic [7:0]    obj_din;
    logic          obj_we;
    logic          busy;
    logic          done;

    // DMA engine side
    modport master (
        input  dma_go,
        input  busak_n,
        input  src_din,
        output busrq_n,
        output dma_sel,
        output src_addr,
        output obj_addr,
        output obj_din,
        output obj_we,
        output busy,
        output done
    );

    // Board side: CPU decoder, Z80 bus arbiter and RAMs
    modport slave (
        output dma_go,
        output busak_n,
        output src_din,
        input  busrq_n,
        input  dma_sel,
        input  src_addr,
        input  obj_addr,
        input  obj_din,
        input  obj_we,
        input  busy,
        input  done
    );
endinterface

// File: rtl/jtpang_objdma.sv
// Object-RAM DMA engine for the Pang main board.
// On a rising edge of dma_go it requests the Z80 bus, copies 2^AW bytes of
// video RAM (starting at SRC_BASE, wrapping at 4 KB) into the object RAM,
// releases the bus and pulses done. Sprites are therefore drawn from a stable
// snapshot rather than from RAM the CPU may be rewriting.
module jtpang_objdma #(
    parameter int          AW       = 9,
    parameter logic [11:0] SRC_BASE = 12'h000
) (
    input  logic              rst_n,
    input  logic              clk,
    input  logic              cen,
    jtpang_objdma_if.master   bus
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_COPY = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    // Source address for the byte after index idx, modulo 4 KB.
    function automatic logic [11:0] f_src_next(input logic [AW-1:0] idx);
        logic [11:0] w_idx;
        w_idx = 12'(idx);
        return SRC_BASE + w_idx + 12'd1;
    endfunction

    // State and datapath registers
    logic [1:0]    r_state;
    logic          r_go_d;
    logic          r_pending;
    logic [AW-1:0] r_cnt;
    logic          r_busrq_n;
    logic          r_dma_sel;
    logic [11:0]   r_src_addr;
    logic [AW-1:0] r_obj_addr;
    logic [7:0]    r_obj_din;
    logic          r_obj_we;
    logic          r_busy;
    logic          r_done;

    // Combinational helpers
    logic          w_go_rise;
    logic          w_consume;
    logic          w_granted;
    logic [AW:0]   w_cnt_inc;
    logic          w_last_byte;
    logic [11:0]   w_src_next;

    // Edge detect, request consumption and counter arithmetic.
    always_comb begin
        w_go_rise   = 1'b0;
        w_consume   = 1'b0;
        w_granted   = 1'b0;
        w_cnt_inc   = {(AW+1){1'b0}};
        w_last_byte = 1'b0;
        w_src_next  = 12'd0;

        w_go_rise   = bus.dma_go & ~r_go_d;
        w_granted   = ~bus.busak_n;
        w_cnt_inc   = {1'b0, r_cnt} + {{AW{1'b0}}, 1'b1};
        // Carry out of the AW-bit counter marks the final byte of the window.
        w_last_byte = w_cnt_inc[AW];
        w_src_next  = f_src_next(r_cnt);

        if (cen && (r_state == ST_IDLE) && r_pending) begin
            w_consume = 1'b1;
        end else begin
            w_consume = 1'b0;
        end
    end

    // Sample dma_go every clk so short pulses between cen ticks are not missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_go_d <= 1'b0;
        end else begin
            r_go_d <= bus.dma_go;
        end
    end

    // One-deep request latch: a new edge wins over a same-cycle consume so that
    // a request arriving exactly as the previous one is accepted is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_go_rise) begin
            r_pending <= 1'b1;
        end else if (w_consume) begin
            r_pending <= 1'b0;
        end
    end

    // Transfer FSM and copy datapath; obj_we and done are single-clk pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {AW{1'b0}};
            r_busrq_n  <= 1'b1;
            r_dma_sel  <= 1'b0;
            r_src_addr <= SRC_BASE;
            r_obj_addr <= {AW{1'b0}};
            r_obj_din  <= 8'h00;
            r_obj_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_obj_we <= 1'b0;
            r_done   <= 1'b0;
            if (cen) begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_pending) begin
                            r_state   <= ST_REQ;
                            r_busrq_n <= 1'b0;
                            r_busy    <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        // Present the first source address on grant so the
                        // read data is ready at the next cen.
                        if (w_granted) begin
                            r_state    <= ST_COPY;
                            r_dma_sel  <= 1'b1;
                            r_cnt      <= {AW{1'b0}};
                            r_src_addr <= SRC_BASE;
                        end
                    end
                    ST_COPY: begin
                        // Without grant everything holds, so the byte at the
                        // held src_addr is simply re-read on resume.
                        if (w_granted) begin
                            r_obj_din  <= bus.src_din;
                            r_obj_addr <= r_cnt;
                            r_obj_we   <= 1'b1;
                            r_cnt      <= w_cnt_inc[AW-1:0];
                            r_src_addr <= w_src_next;
                            if (w_last_byte) begin
                                r_state   <= ST_REL;
                                r_busrq_n <= 1'b1;
                                r_dma_sel <= 1'b0;
                            end
                        end
                    end
                    ST_REL: begin
                        // Wait for the CPU to take the bus back before done.
                        if (bus.busak_n) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_busrq_n <= 1'b1;
                        r_dma_sel <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busrq_n  = r_busrq_n;
    assign bus.dma_sel  = r_dma_sel;
    assign bus.src_addr = r_src_addr;
    assign bus.obj_addr = r_obj_addr;
    assign bus.obj_din  = r_obj_din;
    assign bus.obj_we   = r_obj_we;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Self-checking bench for jtpang_objdma. Two instances: one with SRC_BASE=0,
// one with SRC_BASE=F80 for the 4 KB wrap. The bench acts as the Z80 bus
// arbiter and the RAMs; expected object RAM contents come from the rule
// obj[i] = vram[(SRC_BASE + i) mod 4096].
module tb_jtpang_objdma;

    localparam int AW = 9;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic cen = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0] vram [0:4095];
    logic [7:0] obj0 [0:N-1];
    logic [7:0] obj1 [0:N-1];
    int         tag0 [0:N-1];
    int         tag1 [0:N-1];
    int         epoch = 0;
    int         wr0 = 0, wr1 = 0, done0 = 0, done1 = 0;

    jtpang_objdma_if #(.AW(AW)) bus0 ();
    jtpang_objdma_if #(.AW(AW)) bus1 ();

    jtpang_objdma #(.AW(AW), .SRC_BASE(12'h000)) u_dut0 (
        .rst_n (rst_n),
        .clk   (clk),
        .cen   (cen),
        .bus   (bus0)
    );

    jtpang_objdma #(.AW(AW), .SRC_BASE(12'hF80)) u_dut1 (
        .rst_n (rst_n),
        .clk   (clk),
        .cen   (cen),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    // cen every other clk, changed on negedge so it is stable at posedge
    always @(negedge clk) cen <= ~cen;

    // video RAM with one clk read latency
    always @(posedge clk) begin
        bus0.src_din <= vram[bus0.src_addr];
        bus1.src_din <= vram[bus1.src_addr];
    end

    // object RAM models and write/done counters
    always @(posedge clk) begin
        if (bus0.obj_we) begin
            obj0[bus0.obj_addr] <= bus0.obj_din;
            tag0[bus0.obj_addr] <= tag0[bus0.obj_addr] == epoch ? -1 : epoch;
            wr0 <= wr0 + 1;
        end
        if (bus1.obj_we) begin
            obj1[bus1.obj_addr] <= bus1.obj_din;
            tag1[bus1.obj_addr] <= tag1[bus1.obj_addr] == epoch ? -1 : epoch;
            wr1 <= wr1 + 1;
        end
        if (bus0.done) done0 <= done0 + 1;
        if (bus1.done) done1 <= done1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cen_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            while (cen !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    function automatic logic rq(input int which);
        return (which == 0) ? bus0.busrq_n : bus1.busrq_n;
    endfunction

    function automatic int dn(input int which);
        return (which == 0) ? done0 : done1;
    endfunction

    task automatic set_go(input int which, input logic v);
        if (which == 0) bus0.dma_go = v; else bus1.dma_go = v;
    endtask

    task automatic set_ak(input int which, input logic v);
        if (which == 0) bus0.busak_n = v; else bus1.busak_n = v;
    endtask

    task automatic pulse_go(input int which);
        set_go(which, 1'b1);
        cen_cycles(1);
        set_go(which, 1'b0);
        cen_cycles(1);
    endtask

    task automatic wait_rq(input int which, input logic val, input string tag);
        int n = 0;
        while (rq(which) !== val && n < 2000) begin
            cen_cycles(1);
            n++;
        end
        chk(tag, {31'd0, rq(which)}, {31'd0, val});
    endtask

    task automatic wait_done(input int which, input int target, input string tag);
        int n = 0;
        while (dn(which) < target && n < 100) begin
            cen_cycles(1);
            n++;
        end
        chk(tag, dn(which), target);
    endtask

    // Grant after busrq_n falls, release after it rises, wait for done.
    task automatic serve(input int which, input int delay, input string tag);
        int d0;
        d0 = dn(which);
        wait_rq(which, 1'b0, {tag, " req"});
        cen_cycles(delay);
        set_ak(which, 1'b0);
        wait_rq(which, 1'b1, {tag, " rel"});
        set_ak(which, 1'b1);
        wait_done(which, d0 + 1, {tag, " done"});
    endtask

    task automatic chk_copy(input int which, input int base, input string tag);
        int mism = 0;
        int once = 0;
        for (int i = 0; i < N; i++) begin
            logic [7:0] e;
            e = vram[(base + i) % 4096];
            if (which == 0) begin
                if (obj0[i] !== e) mism++;
                if (tag0[i] != epoch) once++;
            end else begin
                if (obj1[i] !== e) mism++;
                if (tag1[i] != epoch) once++;
            end
        end
        chk({tag, " data"}, mism, 0);
        chk({tag, " once"}, once, 0);
    endtask

    task automatic new_epoch();
        epoch++;
        for (int i = 0; i < 4096; i++) vram[i] = 8'($urandom);
    endtask

    initial begin
        int w_start;
        int d_start;
        int n;
        bus0.dma_go = 1'b0; bus0.busak_n = 1'b1;
        bus1.dma_go = 1'b0; bus1.busak_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            tag0[i] = 0; tag1[i] = 0;
        end
        new_epoch();
        for (int i = 0; i < N; i++) vram[i] = 8'(i) ^ 8'h5A;
        #23;

        // reset values
        chk("rst busrq_n", {31'd0, bus0.busrq_n}, 32'd1);
        chk("rst dma_sel", {31'd0, bus0.dma_sel}, 32'd0);
        chk("rst obj_we", {31'd0, bus0.obj_we}, 32'd0);
        chk("rst obj_addr", {23'd0, bus0.obj_addr}, 32'd0);
        chk("rst obj_din", {24'd0, bus0.obj_din}, 32'd0);
        chk("rst src_addr0", {20'd0, bus0.src_addr}, 32'h000);
        chk("rst src_addr1", {20'd0, bus1.src_addr}, 32'hF80);
        chk("rst busy", {31'd0, bus0.busy}, 32'd0);
        chk("rst done", {31'd0, bus0.done}, 32'd0);
        rst_n = 1'b1;
        cen_cycles(3);

        // basic copy with fill addr^5A, grant 2 cen after request
        w_start = wr0;
        pulse_go(0);
        chk("basic req latency", {31'd0, bus0.busrq_n}, 32'd0);
        chk("basic busy", {31'd0, bus0.busy}, 32'd1);
        chk("basic sel before grant", {31'd0, bus0.dma_sel}, 32'd0);
        cen_cycles(2);
        bus0.busak_n = 1'b0;
        cen_cycles(1);
        chk("basic sel after grant", {31'd0, bus0.dma_sel}, 32'd1);
        wait_rq(0, 1'b1, "basic rel");
        chk("basic sel after copy", {31'd0, bus0.dma_sel}, 32'd0);
        bus0.busak_n = 1'b1;
        wait_done(0, 1, "basic done");
        cen_cycles(4);
        chk("basic writes", wr0 - w_start, N);
        chk("basic done count", done0, 1);
        chk("basic busy end", {31'd0, bus0.busy}, 32'd0);
        chk_copy(0, 0, "basic");

        // delayed grant: 20 cen without busak
        new_epoch();
        w_start = wr0;
        pulse_go(0);
        cen_cycles(20);
        chk("delay busrq", {31'd0, bus0.busrq_n}, 32'd0);
        chk("delay no write", wr0 - w_start, 0);
        chk("delay sel", {31'd0, bus0.dma_sel}, 32'd0);
        bus0.busak_n = 1'b0;
        wait_rq(0, 1'b1, "delay rel");
        bus0.busak_n = 1'b1;
        wait_done(0, 2, "delay done");
        chk("delay writes", wr0 - w_start, N);
        chk_copy(0, 0, "delay");

        // grant dropped for 5 cen at cnt=100
        new_epoch();
        w_start = wr0;
        pulse_go(0);
        cen_cycles(1);
        bus0.busak_n = 1'b0;
        n = 0;
        while (!(bus0.obj_we === 1'b1 && bus0.obj_addr == 9'd99) && n < 1000) begin
            cen_cycles(1);
            n++;
        end
        chk("drop reach 99", {23'd0, bus0.obj_addr}, 32'd99);
        bus0.busak_n = 1'b1;
        cen_cycles(5);
        chk("drop paused writes", wr0 - w_start, 100);
        chk("drop sel held", {31'd0, bus0.dma_sel}, 32'd1);
        chk("drop busrq held", {31'd0, bus0.busrq_n}, 32'd0);
        bus0.busak_n = 1'b0;
        wait_rq(0, 1'b1, "drop rel");
        bus0.busak_n = 1'b1;
        wait_done(0, 3, "drop done");
        chk("drop writes", wr0 - w_start, N);
        chk_copy(0, 0, "drop");

        // retrigger twice during copy -> exactly one extra transfer
        new_epoch();
        w_start = wr0;
        d_start = done0;
        pulse_go(0);
        cen_cycles(2);
        bus0.busak_n = 1'b0;
        cen_cycles(50);
        pulse_go(0);
        cen_cycles(3);
        pulse_go(0);
        wait_rq(0, 1'b1, "retrig rel1");
        bus0.busak_n = 1'b1;
        wait_done(0, d_start + 1, "retrig done1");
        serve(0, 2, "retrig second");
        cen_cycles(20);
        chk("retrig idle busrq", {31'd0, bus0.busrq_n}, 32'd1);
        chk("retrig idle busy", {31'd0, bus0.busy}, 32'd0);
        chk("retrig done count", done0 - d_start, 2);
        chk("retrig writes", wr0 - w_start, 2 * N);

        // source wrap on the F80 instance
        new_epoch();
        w_start = wr1;
        pulse_go(1);
        serve(1, 1, "wrap");
        chk("wrap writes", wr1 - w_start, N);
        chk("wrap first byte", {24'd0, obj1[0]}, {24'd0, vram[12'hF80]});
        chk("wrap byte 128", {24'd0, obj1[128]}, {24'd0, vram[0]});
        chk_copy(1, 12'hF80, "wrap");

        // reset mid-copy at cnt=300 with a request pending
        new_epoch();
        d_start = done0;
        pulse_go(0);
        cen_cycles(1);
        bus0.busak_n = 1'b0;
        n = 0;
        while (!(bus0.obj_we === 1'b1 && bus0.obj_addr == 9'd299) && n < 1000) begin
            cen_cycles(1);
            n++;
        end
        chk("rstmid reach 299", {23'd0, bus0.obj_addr}, 32'd299);
        bus0.dma_go = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid busrq", {31'd0, bus0.busrq_n}, 32'd1);
        chk("rstmid sel", {31'd0, bus0.dma_sel}, 32'd0);
        chk("rstmid we", {31'd0, bus0.obj_we}, 32'd0);
        chk("rstmid busy", {31'd0, bus0.busy}, 32'd0);
        bus0.dma_go = 1'b0;
        bus0.busak_n = 1'b1;
        #30;
        rst_n = 1'b1;
        cen_cycles(20);
        chk("rstmid stays idle", {31'd0, bus0.busrq_n}, 32'd1);
        chk("rstmid idle busy", {31'd0, bus0.busy}, 32'd0);
        chk("rstmid no done", done0 - d_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
